spi_flash_responder: RTL

Synthesizable SPI-flash target that answers the serial flash commands issued by the team's SPI memory master (READ 03h, PAGE PROGRAM 02h, WREN 06h, WRDI 04h, SECTOR ERASE 20h, RDSR 05h). It oversamples the SPI pins in the system clock domain and backs them with a small on-chip byte array. The block serves as the bring-up and regression target for the master in simulation and on FPGA, in place of a physical flash.

---
 rtl/spi_flash_responder_if.sv | 22 ++
 rtl/spi_flash_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder_if.sv
// SPI flash pin bundle between a master and the flash responder.
// The master drives clock, select and data out; the responder drives
// data in, its output enable and the two status flags.
interface spi_flash_responder_if;
    logic sclk;
    logic ncs;
    logic mosi;
    logic miso;
    logic miso_oe;
    logic busy;
    logic wel;

    modport master (
        output sclk, ncs, mosi,
        input  miso, miso_oe, busy, wel
    );

    modport slave (
        input  sclk, ncs, mosi,
        output miso, miso_oe, busy, wel
    );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI-flash target (mode 0) oversampled in the clk domain, backed by a
// small byte array. Supports READ, PAGE PROGRAM, WREN, WRDI, SECTOR ERASE
// and RDSR. A frame that opens while an erase is running is treated as a
// busy frame, and its first status byte reports the status seen when the
// frame opened, because an erase is shorter than one opcode byte.
module spi_flash_responder #(
    parameter int DEPTH  = 256,
    parameter int PAGE   = 64,
    parameter int SECTOR = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_flash_responder_if.slave  spi
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PAGE_MASK   = AW'(PAGE - 1);
    localparam logic [AW-1:0] SECTOR_MASK = AW'(SECTOR - 1);

    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_SE   = 8'h20;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, RDATA, WDATA, STATUS, IGNORE, ERASE
    } state_t;

    state_t state, state_next;

    logic [7:0]    mem [DEPTH];
    logic [2:0]    sclk_sync, ncs_sync;
    logic [1:0]    mosi_sync;
    logic [2:0]    bit_idx, tx_idx;
    logic [5:0]    frame_bits;
    logic [6:0]    shift_in;
    logic [7:0]    tx_sr, wr_data;
    logic [AW-1:0] addr, erase_base, erase_cnt;
    logic [1:0]    status_snap;
    logic          cmd_read, wren_pend, wrdi_pend, pp_pend, frame_busy, status_first;
    logic          fetch, wr_en, miso_q, miso_oe_c, busy, wel;

    logic       mosi_s, ncs_rise, ncs_fall, sclk_rise, sclk_fall, byte_done, in_busy, enter_tx;
    logic [7:0] byte_now;

    assign mosi_s    = mosi_sync[1];
    assign ncs_fall  = ~ncs_sync[1] & ncs_sync[2];
    assign ncs_rise  = ncs_sync[1] & ~ncs_sync[2];
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2] & ~ncs_rise;
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2] & ~ncs_rise;
    assign byte_done = sclk_rise && (bit_idx == 3'd7);
    assign byte_now  = {shift_in, mosi_s};
    assign in_busy   = busy | frame_busy;
    assign enter_tx  = (state_next != state) && (state_next == RDATA || state_next == STATUS);

    // Two-flop synchronizers plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= 3'b000;
            ncs_sync  <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi.sclk};
            ncs_sync  <= {ncs_sync[1:0], spi.ncs};
            mosi_sync <= {mosi_sync[0], spi.mosi};
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Frame state transitions: select edges dominate, then opcode and address completion.
    always_comb begin
        state_next = state;
        if (ncs_rise) begin
            state_next = IDLE;
        end else if (ncs_fall) begin
            state_next = CMD;
        end else if (byte_done && state == CMD) begin
            if (in_busy) begin
                state_next = (byte_now == OP_RDSR) ? STATUS : IGNORE;
            end else begin
                case (byte_now)
                    OP_READ: state_next = ADDR;
                    OP_PP:   state_next = wel ? ADDR : IGNORE;
                    OP_SE:   state_next = wel ? ERASE : IGNORE;
                    OP_RDSR: state_next = STATUS;
                    default: state_next = IGNORE;
                endcase
            end
        end else if (byte_done && state == ADDR && frame_bits == 6'd31) begin
            state_next = cmd_read ? RDATA : WDATA;
        end
    end

    // The responder only drives the data line in a read or status phase with select low.
    always_comb begin
        miso_oe_c = 1'b0;
        if ((state == RDATA || state == STATUS) && !ncs_sync[1]) miso_oe_c = 1'b1;
    end

    assign spi.miso_oe = miso_oe_c;
    assign spi.miso    = miso_q & miso_oe_c;
    assign spi.busy    = busy;
    assign spi.wel     = wel;

    // Per-frame datapath: bit counting, address capture, transmit shifting and byte fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx      <= '0;
            tx_idx       <= '0;
            frame_bits   <= '0;
            shift_in     <= '0;
            tx_sr        <= '0;
            wr_data      <= '0;
            addr         <= '0;
            status_snap  <= '0;
            cmd_read     <= 1'b0;
            wren_pend    <= 1'b0;
            wrdi_pend    <= 1'b0;
            pp_pend      <= 1'b0;
            frame_busy   <= 1'b0;
            status_first <= 1'b0;
            fetch        <= 1'b0;
            wr_en        <= 1'b0;
            miso_q       <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            fetch <= enter_tx;
            if (ncs_fall) begin
                bit_idx      <= '0;
                tx_idx       <= '0;
                frame_bits   <= '0;
                cmd_read     <= 1'b0;
                wren_pend    <= 1'b0;
                wrdi_pend    <= 1'b0;
                pp_pend      <= 1'b0;
                miso_q       <= 1'b0;
                frame_busy   <= busy;
                status_snap  <= {wel, busy};
                status_first <= 1'b1;
            end else begin
                if (sclk_rise && state != IDLE) begin
                    bit_idx  <= bit_idx + 3'd1;
                    shift_in <= byte_now[6:0];
                    if (frame_bits != 6'h3F) frame_bits <= frame_bits + 6'd1;
                    if (state == CMD && bit_idx == 3'd7) begin
                        cmd_read  <= (byte_now == OP_READ);
                        wren_pend <= (byte_now == OP_WREN) && !in_busy;
                        wrdi_pend <= (byte_now == OP_WRDI) && !in_busy;
                        pp_pend   <= (byte_now == OP_PP) && wel && !in_busy;
                    end
                    if (state == ADDR || state == ERASE) addr <= AW'({addr, mosi_s});
                    if (state == WDATA && bit_idx == 3'd7) begin
                        wr_en   <= 1'b1;
                        wr_data <= byte_now;
                    end
                end
                if (sclk_fall && (state == RDATA || state == STATUS)) begin
                    miso_q <= tx_sr[7];
                    tx_sr  <= {tx_sr[6:0], 1'b0};
                    tx_idx <= tx_idx + 3'd1;
                    if (tx_idx == 3'd7) fetch <= 1'b1;
                end
                if (fetch) begin
                    if (state == STATUS) begin
                        tx_sr        <= status_first ? {6'b0, status_snap} : {6'b0, wel, busy};
                        status_first <= 1'b0;
                    end else begin
                        tx_sr <= mem[addr];
                        addr  <= addr + AW'(1);
                    end
                end
                if (wr_en) addr <= (addr & ~PAGE_MASK) | ((addr + AW'(1)) & PAGE_MASK);
            end
        end
    end

    // Write-enable latch and the sector erase sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wel        <= 1'b0;
            busy       <= 1'b0;
            erase_base <= '0;
            erase_cnt  <= '0;
        end else begin
            if (ncs_rise) begin
                if (wren_pend)                 wel <= 1'b1;
                else if (wrdi_pend || pp_pend) wel <= 1'b0;
                if (state == ERASE && frame_bits == 6'd32 && !busy) begin
                    busy       <= 1'b1;
                    erase_base <= addr & ~SECTOR_MASK;
                    erase_cnt  <= '0;
                end
            end
            if (busy) begin
                erase_cnt <= erase_cnt + AW'(1);
                if (erase_cnt == SECTOR_MASK) begin
                    busy <= 1'b0;
                    wel  <= 1'b0;
                end
            end
        end
    end

    // Backing array: erase fill has priority over page-program writes.
    always_ff @(posedge clk) begin
        if (busy)       mem[erase_base | erase_cnt] <= 8'hFF;
        else if (wr_en) mem[addr] <= wr_data;
    end
endmodule
